// File: rtl/timer_pkg.sv
// Shared kitchen-timer definitions: PSW channel states, default timings, button indices.
package timer_pkg;

  localparam int unsigned N_BTN_DEF         = 4;
  localparam int unsigned DEB_CYCLES_DEF    = 20;
  localparam int unsigned LONG_CYCLES_DEF   = 500;
  localparam int unsigned REPEAT_CYCLES_DEF = 100;
  localparam int unsigned CNT_W_DEF         = 10;

  localparam int unsigned PSW_START = 0;
  localparam int unsigned PSW_STOP  = 1;

  typedef logic [2:0] psw_state_t;
  localparam psw_state_t ST_IDLE  = 3'd0;
  localparam psw_state_t ST_DEB_P = 3'd1;
  localparam psw_state_t ST_HELD  = 3'd2;
  localparam psw_state_t ST_RPT   = 3'd3;
  localparam psw_state_t ST_DEB_R = 3'd4;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic rept;
  } psw_evt_t;

  // True when a CNT_W-bit counter can hold every terminal count.
  function automatic bit cnt_fits(input int unsigned w, input int unsigned deb,
                                  input int unsigned lng, input int unsigned rpt);
    int unsigned mx;
    mx = deb;
    if (lng > mx) mx = lng;
    if (rpt > mx) mx = rpt;
    return (deb >= 1) && ((longint'(1) << w) > longint'(mx));
  endfunction

endpackage

// File: rtl/psw_conditioner_if.sv
// Push-button bank bus: raw PSW levels in, conditioned level/event vectors out.
interface psw_conditioner_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] PSW_IN;
  logic [N_BTN-1:0] LEVEL;
  logic [N_BTN-1:0] PRESS;
  logic [N_BTN-1:0] RELEASE;
  logic [N_BTN-1:0] REPT;

  modport master (output PSW_IN, input LEVEL, input PRESS, input RELEASE, input REPT);
  modport slave  (input PSW_IN, output LEVEL, output PRESS, output RELEASE, output REPT);
endinterface

// File: rtl/psw_debounce_ch.sv
// One PSW channel: 2-flop synchroniser, debounce FSM, press/release/auto-repeat events.
// Auto-repeat (RPT state, REPT pulses) is compiled only with PSW_AUTO_REPEAT_EN defined.
module psw_debounce_ch
  import timer_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input  logic     CLOCK,
  input  logic     RESET,
  input  logic     psw_in,
  output psw_evt_t evt
);

  if (!cnt_fits(CNT_W, DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) begin : g_cnt_w_bad
    $error("psw_debounce_ch: CNT_W too narrow or DEB_CYCLES is 0");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam bit               DEB_ONE  = (DEB_CYCLES == 1);
`ifdef PSW_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             s1, s;
  psw_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n, rel_n, rept_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    rel_n   = 1'b0;
    rept_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (s) begin
          // A one-sample debounce accepts the press without visiting DEB_P.
          if (DEB_ONE) begin
            state_n = ST_HELD;
            cnt_n   = '0;
            press_n = 1'b1;
          end else begin
            state_n = ST_DEB_P;
            cnt_n   = CNT_W'(1);
          end
        end
      end
      ST_DEB_P: begin
        if (!s) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = ST_HELD;
          cnt_n   = '0;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!s) begin
          if (DEB_ONE) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            rel_n   = 1'b1;
          end else begin
            state_n = ST_DEB_R;
            cnt_n   = CNT_W'(1);
          end
        end
`ifdef PSW_AUTO_REPEAT_EN
        else if (cnt == LONG_LAST) begin
          state_n = ST_RPT;
          cnt_n   = '0;
          rept_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`else
        else begin
          cnt_n = '0;
        end
`endif
      end
`ifdef PSW_AUTO_REPEAT_EN
      ST_RPT: begin
        if (!s) begin
          if (DEB_ONE) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            rel_n   = 1'b1;
          end else begin
            state_n = ST_DEB_R;
            cnt_n   = CNT_W'(1);
          end
        end else if (cnt == RPT_LAST) begin
          cnt_n  = '0;
          rept_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
`endif
      ST_DEB_R: begin
        if (s) begin
          state_n = ST_HELD;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          rel_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= ST_IDLE;
      cnt   <= '0;
      evt   <= '0;
    end else begin
      s1        <= psw_in;
      s         <= s1;
      state     <= state_n;
      cnt       <= cnt_n;
      evt.level <= (state_n != ST_IDLE) && (state_n != ST_DEB_P);
      evt.press <= press_n;
      evt.rel   <= rel_n;
      evt.rept  <= rept_n;
    end
  end

endmodule

// File: rtl/psw_conditioner.sv
// Kitchen-timer PSW front end: N_BTN independent debounce channels on the CLOCK domain.
// Define PSW_AUTO_REPEAT_EN to build the held-button auto-repeat (REPT) logic.
module psw_conditioner
  import timer_pkg::*;
#(
  parameter int unsigned N_BTN         = N_BTN_DEF,
  parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = CNT_W_DEF
) (
  input logic               CLOCK,
  input logic               RESET,
  psw_conditioner_if.slave  bus
);

  psw_evt_t         evt [N_BTN];
  logic [N_BTN-1:0] level_v, press_v, rel_v, rept_v;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    psw_debounce_ch #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .psw_in(bus.PSW_IN[i]),
      .evt   (evt[i])
    );
  end

  always_comb begin
    level_v = '0;
    press_v = '0;
    rel_v   = '0;
    rept_v  = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      level_v[i] = evt[i].level;
      press_v[i] = evt[i].press;
      rel_v[i]   = evt[i].rel;
      rept_v[i]  = evt[i].rept;
    end
  end

  assign bus.LEVEL   = level_v;
  assign bus.PRESS   = press_v;
  assign bus.RELEASE = rel_v;
  assign bus.REPT    = rept_v;

endmodule

// File: tb/tb_psw_conditioner.sv
// Bench for psw_conditioner: default-timing DUT plus a DEB_CYCLES=1 DUT, checked against a run-length model.
module tb_psw_conditioner;
  import timer_pkg::*;

  localparam int NB = 4;
  localparam int D0 = 20, L0 = 500, R0 = 100;
  localparam int D1 = 1,  L1 = 4,   R1 = 3;
`ifdef PSW_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic CLOCK = 1'b0;
  logic RESET = 1'b1;

  psw_conditioner_if #(.N_BTN(NB)) bus0 ();
  psw_conditioner_if #(.N_BTN(NB)) bus1 ();

  psw_conditioner #(.N_BTN(NB), .DEB_CYCLES(D0), .LONG_CYCLES(L0), .REPEAT_CYCLES(R0), .CNT_W(10))
    u_dut0 (.CLOCK(CLOCK), .RESET(RESET), .bus(bus0.slave));
  psw_conditioner #(.N_BTN(NB), .DEB_CYCLES(D1), .LONG_CYCLES(L1), .REPEAT_CYCLES(R1), .CNT_W(3))
    u_dut1 (.CLOCK(CLOCK), .RESET(RESET), .bus(bus1.slave));

  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;
  int per      = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (period %0d): got %b expected %b", name, per, act, exp);
    end
  endtask

  // Model: s lags raw by two samples; a level flips after deb equal samples of the
  // opposite value; age counts uninterrupted held samples since press or release bounce.
  typedef struct packed {
    bit sh1; bit sh2; bit level;
    int run; int age;
    bit press; bit rel; bit rept;
  } mch_t;

  mch_t m0 [NB];
  mch_t m1 [NB];

  function automatic mch_t mstep(input mch_t m, input bit raw, input int deb, input int lng, input int rpt);
    mch_t n;
    bit   s;
    n = m;
    s = m.sh2;
    n.sh2 = m.sh1;
    n.sh1 = raw;
    n.press = 1'b0; n.rel = 1'b0; n.rept = 1'b0;
    if (!m.level) begin
      n.run = s ? m.run + 1 : 0;
      if (n.run == deb) begin n.level = 1'b1; n.press = 1'b1; n.run = 0; n.age = 0; end
    end else if (!s) begin
      n.run = m.run + 1;
      if (n.run == deb) begin n.level = 1'b0; n.rel = 1'b1; n.run = 0; end
    end else if (m.run != 0) begin
      n.run = 0;
      n.age = 0;
    end else begin
      n.age  = m.age + 1;
      n.rept = AR && (n.age >= lng) && (((n.age - lng) % rpt) == 0);
    end
    return n;
  endfunction

  always @(posedge CLOCK or posedge RESET) begin
    for (int i = 0; i < NB; i++) begin
      if (RESET) begin
        m0[i] = '0;
        m1[i] = '0;
      end else begin
        m0[i] = mstep(m0[i], bus0.PSW_IN[i], D0, L0, R0);
        m1[i] = mstep(m1[i], bus1.PSW_IN[i], D1, L1, R1);
      end
    end
  end

  function automatic logic [3:0] mvec(input int d, input int f);
    logic [3:0] v;
    mch_t       m;
    v = '0;
    for (int i = 0; i < NB; i++) begin
      m = (d == 0) ? m0[i] : m1[i];
      case (f)
        0:       v[i] = m.level;
        1:       v[i] = m.press;
        2:       v[i] = m.rel;
        default: v[i] = m.rept;
      endcase
    end
    return v;
  endfunction

  always @(negedge CLOCK) begin
    check("d0_LEVEL",   bus0.LEVEL,   mvec(0, 0));
    check("d0_PRESS",   bus0.PRESS,   mvec(0, 1));
    check("d0_RELEASE", bus0.RELEASE, mvec(0, 2));
    check("d0_REPT",    bus0.REPT,    mvec(0, 3));
    check("d1_LEVEL",   bus1.LEVEL,   mvec(1, 0));
    check("d1_PRESS",   bus1.PRESS,   mvec(1, 1));
    check("d1_RELEASE", bus1.RELEASE, mvec(1, 2));
    check("d1_REPT",    bus1.REPT,    mvec(1, 3));
  end

  task automatic step();
    @(negedge CLOCK);
    per++;
  endtask

  task automatic run_to(input int p);
    while (per < p) step();
  endtask

  task automatic drive(input logic [3:0] v);
    bus0.PSW_IN = v;
    bus1.PSW_IN = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d0_all"}, bus0.LEVEL | bus0.PRESS | bus0.RELEASE | bus0.REPT, 4'b0000);
    check({tag, "_d1_all"}, bus1.LEVEL | bus1.PRESS | bus1.RELEASE | bus1.REPT, 4'b0000);
  endtask

  // Period p is the interval ending at posedge p; inputs and checks happen at its negedge.
  initial begin
    logic [3:0] rexp;
    bit         bpat [5];
    bpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rexp = AR ? 4'b0100 : 4'b0000;

    drive(4'b0000);
    repeat (3) @(negedge CLOCK);
    check_all_zero("reset_state");
    per = 0;
    #1 RESET = 1'b0;

    // Clean press on bit 0, held 100 periods
    run_to(10);  drive(4'b0001 << PSW_START);
    run_to(13);  check("d1_press_deb1_c13", bus1.PRESS, 4'b0001);
    run_to(31);  check("press0_c31", bus0.PRESS, 4'b0000);
    run_to(32);  check("press0_c32", bus0.PRESS, 4'b0001);
                 check("level0_c32", bus0.LEVEL, 4'b0001);
                 check("model_press0_c32", mvec(0, 1), 4'b0001);
    run_to(33);  check("press0_c33", bus0.PRESS, 4'b0000);
    run_to(110); drive(4'b0000);
    run_to(131); check("rel0_c131", bus0.RELEASE, 4'b0000);
    run_to(132); check("rel0_c132", bus0.RELEASE, 4'b0001);
                 check("level0_c132", bus0.LEVEL, 4'b0000);

    // Press bounce on bit 1
    for (int k = 0; k < 5; k++) begin
      run_to(140 + k);
      drive({2'b00, bpat[k], 1'b0});
    end
    run_to(145); drive(4'b0010);
    run_to(166); check("press1_c166", bus0.PRESS, 4'b0000);
    run_to(167); check("press1_c167", bus0.PRESS, 4'b0010);
                 check("model_press1_c167", mvec(0, 1), 4'b0010);
    run_to(200); drive(4'b0000);

    // Long hold on bit 2: repeats at PRESS+500, +600, +700, +800 when enabled
    run_to(250); drive(4'b0100);
    run_to(272); check("press2_c272", bus0.PRESS, 4'b0100);
    run_to(771); check("rept2_c771", bus0.REPT, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      run_to(772 + 100 * k);
      check("rept2_pulse", bus0.REPT, rexp);
    end
    check("model_rept2_c1072", mvec(0, 3), rexp);
    run_to(1100); drive(4'b0000);
    run_to(1122); check("rel2_c1122", bus0.RELEASE, 4'b0100);

    // Release bounce on bit 3
    run_to(1150); drive(4'b1000);
    run_to(1172); check("press3_c1172", bus0.PRESS, 4'b1000);
    run_to(1200); drive(4'b0000);
    run_to(1201); drive(4'b0000);
    run_to(1202); drive(4'b1000);
    run_to(1203); drive(4'b0000);
    run_to(1224); check("level3_c1224", bus0.LEVEL, 4'b1000);
                  check("rel3_c1224", bus0.RELEASE, 4'b0000);
    run_to(1225); check("rel3_c1225", bus0.RELEASE, 4'b1000);
                  check("level3_c1225", bus0.LEVEL, 4'b0000);
                  check("model_rel3_c1225", mvec(0, 2), 4'b1000);

    // Reset while bit 0 is held
    run_to(1300); drive(4'b0001);
    run_to(1322); check("press0_c1322", bus0.PRESS, 4'b0001);
    run_to(1400); #1 RESET = 1'b1;
    run_to(1401); check_all_zero("in_reset_1401");
    run_to(1404); check_all_zero("in_reset_1404");
    run_to(1405); #1 RESET = 1'b0;
    run_to(1426); check("press0_c1426", bus0.PRESS, 4'b0000);
                  check("rel0_after_rst", bus0.RELEASE, 4'b0000);
    run_to(1427); check("press0_c1427", bus0.PRESS, 4'b0001);
    run_to(1500); drive(4'b0000);
    run_to(1522); check("rel0_c1522", bus0.RELEASE, 4'b0001);

    // All channels together
    run_to(1600); drive(4'b1111);
    run_to(1622); check("press_all_c1622", bus0.PRESS, 4'b1111);
    run_to(1700); drive(4'b0000);
    run_to(1722); check("rel_all_c1722", bus0.RELEASE, 4'b1111);
    run_to(1740);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psw_conditioner.md
Name: psw_conditioner

Overview:
- Input-side front end for the kitchen-timer top. Conditions the raw push-button bank so the timer logic receives clean, single-cycle events instead of sampling bouncing PSW levels.
- Per button, it:
  - synchronises the raw input,
  - debounces it,
  - emits press and release pulses,
  - emits auto-repeat pulses while the button is held, used for minute setting.
- Sits between the board PSW pins and the timer control FSM, in the CLOCK (1 kHz) domain.

Parameters:
- N_BTN, 4, number of buttons/channels.
- DEB_CYCLES, 20, consecutive equal samples required to accept a level change (20 ms at 1 kHz).
- LONG_CYCLES, 500, held cycles after PRESS before the first repeat pulse.
- REPEAT_CYCLES, 100, cycles between subsequent repeat pulses.
- CNT_W, 10, per-channel counter width; must satisfy 2^CNT_W > max(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES).

Ports:
- CLOCK  in  1  system clock, 1 kHz.
- RESET  in  1  asynchronous, active-high reset.
- PSW_IN  in  N_BTN  raw buttons, 1 = pressed; bit 0 = leftmost.
- LEVEL  out  N_BTN  debounced level, 1 = held.
- PRESS  out  N_BTN  one-cycle pulse on accepted press.
- RELEASE  out  N_BTN  one-cycle pulse on accepted release.
- REPT  out  N_BTN  one-cycle auto-repeat pulse.

Behaviour:
- Reset: RESET is asynchronous and active-high; clock is CLOCK.
  - While RESET=1: synchroniser flops 0, all FSMs in IDLE, all counters 0.
  - While RESET=1: LEVEL, PRESS, RELEASE and REPT are 0.
- Synchroniser: a 2-flop synchroniser per bit; s = second-stage output. Channels are fully independent.
- Per-channel FSM states: IDLE, DEB_P, HELD, RPT, DEB_R.
- IDLE (LEVEL=0):
  - s=1 → DEB_P, cnt=1.
- DEB_P (LEVEL=0):
  - s=0 → IDLE, cnt=0 (bounce rejected, no pulse).
  - s=1 and cnt=DEB_CYCLES-1 → HELD, cnt=0, PRESS=1 for that cycle.
  - Otherwise cnt+1.
- HELD (LEVEL=1):
  - s=0 → DEB_R, cnt=1.
  - cnt=LONG_CYCLES-1 → RPT, cnt=0, REPT=1.
  - Otherwise cnt+1.
- RPT (LEVEL=1):
  - s=0 → DEB_R, cnt=1.
  - cnt=REPEAT_CYCLES-1 → cnt=0, REPT=1.
  - Otherwise cnt+1.
- DEB_R (LEVEL=1):
  - s=1 → HELD, cnt=0 (release bounce rejected; the long-press timer restarts, no pulse).
  - s=0 and cnt=DEB_CYCLES-1 → IDLE, cnt=0, RELEASE=1.
  - Otherwise cnt+1.
- Outputs are registered: pulses assert in the cycle after the transition edge and last exactly 1 cycle.
- Latency: a clean raw press stable from edge t gives PRESS high in cycle t+2+DEB_CYCLES. Release latency is identical.
- PRESS and RELEASE never assert together on one channel. REPT never coincides with PRESS.
- Counters never exceed their terminal values; no wrap-around.
- Simultaneous presses on several channels are handled independently and may pulse in the same cycle.
- Reset mid-operation: all state is discarded, with no RELEASE emitted.
  - A button still held when RESET deasserts is processed as a new press and produces PRESS after 2+DEB_CYCLES cycles.
- DEB_CYCLES=1 is legal: a single sample accepts the change.

Optional Feature:
- Macro: PSW_AUTO_REPEAT_EN.
- Defined: RPT state and REPT pulses behave as above.
- Undefined:
  - The RPT state and the repeat logic are not compiled.
  - HELD stays in HELD until release, and cnt holds at 0 in HELD.
  - REPT is tied to 0.
  - LONG_CYCLES and REPEAT_CYCLES are ignored.
  - PRESS, RELEASE and LEVEL timing is unchanged.

Decomposition:
- Shared package (timer_pkg):
  - FSM state typedef (IDLE, DEB_P, HELD, RPT, DEB_R).
  - Default timing constants: DEB_CYCLES_DEF, LONG_CYCLES_DEF, REPEAT_CYCLES_DEF.
  - PSW bit-index constants: PSW_START=0, PSW_STOP=1.
- Sub-module psw_debounce_ch holds one channel (synchroniser, FSM, counter). The top generates N_BTN instances and concatenates the outputs.

Test Plan:
- Clean press: PSW_IN[0] goes 0→1 at cycle 10 and is held 100 cycles → PRESS[0] high only in cycle 32 (DEB=20). LEVEL[0] rises with it. Other bits stay 0.
- Press bounce: PSW_IN[1] pattern 1,0,1,1,0 over 5 cycles, then stable 1 → no pulse during the bounce. Exactly one PRESS[1], 22 cycles after the last 0→1 edge.
- Auto-repeat (macro defined): hold PSW_IN[2] for 800 cycles after PRESS → REPT at PRESS+500, +600, +700, +800 (4 pulses).
- Auto-repeat (macro undefined): same stimulus → REPT stays 0. PRESS and RELEASE timing is identical to the previous case.
- Release bounce: while held, PSW_IN[3] pattern 0,0,1,0 then stable 0 → one RELEASE[3] 22 cycles after the final 1→0. LEVEL[3] falls in the same cycle.
- Reset mid-hold: RESET pulses during HELD with PSW_IN[0] kept at 1 → all outputs are 0 during reset. No RELEASE. PRESS[0] occurs 22 cycles after RESET deasserts.
